// File: rtl/ch_scan_pkg.sv
// Shared definitions for the channel scan controller.
// Covers the register map offsets, MODE encoding, FSM states and one-hot helpers.
package ch_scan_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_DWELL  = 2'd1,
    ST_SETTLE = 2'd2
  } scan_state_t;

  localparam logic [7:0] OFF_CH_SEL  = 8'd0;
  localparam logic [7:0] OFF_CH_MASK = 8'd1;
  localparam logic [7:0] OFF_MODE    = 8'd2;
  localparam logic [7:0] OFF_DWELL   = 8'd3;
  localparam logic [7:0] OFF_STATUS  = 8'd4;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  function automatic logic is_onehot16(input logic [15:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (v[i]) n++;
    end
    return (n == 1);
  endfunction

  function automatic logic [3:0] oh2idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ch_next_sel.sv
// Next enabled channel search: the lowest enabled channel above cur_idx,
// otherwise a wrap to the lowest enabled channel when that differs from cur_idx.
module ch_next_sel #(
  parameter int unsigned CH_NUM = 4
) (
  input  logic [CH_NUM-1:0] mask,
  input  logic [3:0]        cur_idx,
  output logic              found,
  output logic              wrap,
  output logic [3:0]        nxt_idx,
  output logic [CH_NUM-1:0] nxt_sel
);

  logic       up_hit;
  logic       lo_hit;
  logic [3:0] up_idx;
  logic [3:0] lo_idx;

  always_comb begin
    up_hit = 1'b0;
    lo_hit = 1'b0;
    up_idx = '0;
    lo_idx = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (mask[i] && !lo_hit) begin
        lo_hit = 1'b1;
        lo_idx = 4'(i);
      end
      if (mask[i] && !up_hit && (i > 32'(cur_idx))) begin
        up_hit = 1'b1;
        up_idx = 4'(i);
      end
    end
  end

  always_comb begin
    found   = 1'b0;
    wrap    = 1'b0;
    nxt_idx = cur_idx;
    nxt_sel = '0;
    if (up_hit) begin
      found   = 1'b1;
      nxt_idx = up_idx;
    end else if (lo_hit && (lo_idx != cur_idx)) begin
      found   = 1'b1;
      wrap    = 1'b1;
      nxt_idx = lo_idx;
    end
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      nxt_sel[i] = found && (4'(i) == nxt_idx);
    end
  end

endmodule

// File: rtl/ch_scan_ctrl.sv
// Channel scan controller: host register window, and a manual/auto scan FSM
// with per-channel dwell and post-switch settle blanking.
module ch_scan_ctrl
  import ch_scan_pkg::*;
#(
  parameter int unsigned CH_NUM     = 4,
  parameter logic [15:0] DWELL_DEF  = 16'd1000,
  parameter int unsigned SETTLE_CYC = 8,
  parameter logic [7:0]  ADDR_BASE  = 8'h10
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              m_wr,
  input  logic              m_rd,
  input  logic [7:0]        m_addr,
  input  logic [15:0]       m_wrdata,
  output logic [15:0]       m_rddata,
  output logic [CH_NUM-1:0] ch_sel,
  output logic [3:0]        ch_idx,
  output logic              ch_valid,
  output logic              ch_switch,
  output logic              scan_wrap
);

  localparam logic [7:0]        A_SEL     = ADDR_BASE + OFF_CH_SEL;
  localparam logic [7:0]        A_MASK    = ADDR_BASE + OFF_CH_MASK;
  localparam logic [7:0]        A_MODE    = ADDR_BASE + OFF_MODE;
  localparam logic [7:0]        A_DWELL   = ADDR_BASE + OFF_DWELL;
  localparam logic [7:0]        A_STATUS  = ADDR_BASE + OFF_STATUS;
  localparam logic [7:0]        SETTLE_LD = 8'(SETTLE_CYC);
  localparam logic [CH_NUM-1:0] SEL_RST   = CH_NUM'(1);

  scan_state_t       state_q, state_n;
  logic [CH_NUM-1:0] sel_q, sel_n, mask_q, mask_n;
  logic [3:0]        idx_q, idx_n;
  logic              mode_q, mode_n, err_q, err_n;
  logic [15:0]       dwell_q, dwell_n, cnt_q, cnt_n, rd_q, rd_n;
  logic [7:0]        settle_q, settle_n;
  logic              sw_q, sw_n, wrap_q, wrap_n;

  logic              wr_sel, wr_mask, wr_mode, wr_dwell, wr_status;
  logic [CH_NUM-1:0] sel_wr;
  logic              sel_ok;
  logic [15:0]       dwell_eff;
  logic              change;
  logic [CH_NUM-1:0] target;
  logic [3:0]        target_idx;

  logic              nx_found, nx_wrap;
  logic [3:0]        nx_idx;
  logic [CH_NUM-1:0] nx_sel;

  assign wr_sel    = m_wr && (m_addr == A_SEL);
  assign wr_mask   = m_wr && (m_addr == A_MASK);
  assign wr_mode   = m_wr && (m_addr == A_MODE);
  assign wr_dwell  = m_wr && (m_addr == A_DWELL);
  assign wr_status = m_wr && (m_addr == A_STATUS);
  assign sel_wr    = m_wrdata[CH_NUM-1:0];
  assign sel_ok    = is_onehot16(16'(sel_wr));

  // Decision sees the mask as updated by a same-cycle write.
  ch_next_sel #(.CH_NUM(CH_NUM)) u_next (
    .mask    (mask_n),
    .cur_idx (idx_q),
    .found   (nx_found),
    .wrap    (nx_wrap),
    .nxt_idx (nx_idx),
    .nxt_sel (nx_sel)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= ST_MANUAL;
      sel_q    <= SEL_RST;
      idx_q    <= '0;
      mask_q   <= '1;
      mode_q   <= MODE_MANUAL;
      dwell_q  <= DWELL_DEF;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      settle_q <= '0;
      sw_q     <= 1'b0;
      wrap_q   <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_n;
      sel_q    <= sel_n;
      idx_q    <= idx_n;
      mask_q   <= mask_n;
      mode_q   <= mode_n;
      dwell_q  <= dwell_n;
      err_q    <= err_n;
      cnt_q    <= cnt_n;
      settle_q <= settle_n;
      sw_q     <= sw_n;
      wrap_q   <= wrap_n;
      rd_q     <= rd_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    sel_n      = sel_q;
    idx_n      = idx_q;
    mask_n     = mask_q;
    mode_n     = mode_q;
    dwell_n    = dwell_q;
    err_n      = err_q;
    cnt_n      = cnt_q;
    settle_n   = settle_q;
    sw_n       = 1'b0;
    wrap_n     = 1'b0;
    change     = 1'b0;
    target     = sel_q;
    target_idx = idx_q;

    if (wr_mask)            mask_n  = m_wrdata[CH_NUM-1:0];
    if (wr_mode)            mode_n  = m_wrdata[0];
    if (wr_dwell)           dwell_n = m_wrdata;
    if (wr_status)          err_n   = 1'b0;
    if (wr_sel && !sel_ok)  err_n   = 1'b1;
    dwell_eff = (dwell_n == '0) ? 16'd1 : dwell_n;

    case (state_q)
      ST_MANUAL: begin
        if (mode_n == MODE_AUTO) begin
          state_n = ST_DWELL;
          cnt_n   = dwell_eff;
        end
      end
      ST_DWELL: begin
        if (mode_n == MODE_MANUAL) begin
          state_n = ST_MANUAL;
        end else if (cnt_q <= 16'd1) begin
          if (nx_found) begin
            change     = 1'b1;
            target     = nx_sel;
            target_idx = nx_idx;
            wrap_n     = nx_wrap;
          end else begin
            cnt_n = dwell_eff;
          end
        end else begin
          cnt_n = cnt_q - 16'd1;
        end
      end
      ST_SETTLE: begin
        if (settle_q <= 8'd1) begin
          state_n = (mode_n == MODE_AUTO) ? ST_DWELL : ST_MANUAL;
          cnt_n   = dwell_eff;
        end else begin
          settle_n = settle_q - 8'd1;
        end
      end
      default: state_n = ST_MANUAL;
    endcase

    // A valid host select replaces any automatic step decided above.
    if (wr_sel && sel_ok) begin
      if (sel_wr != sel_q) begin
        change     = 1'b1;
        target     = sel_wr;
        target_idx = oh2idx(16'(sel_wr));
        wrap_n     = 1'b0;
      end else if ((state_q == ST_DWELL) && (mode_n == MODE_AUTO)) begin
        change  = 1'b0;
        wrap_n  = 1'b0;
        state_n = ST_DWELL;
        cnt_n   = dwell_eff;
      end
    end

    if (change) begin
      sel_n = target;
      idx_n = target_idx;
      sw_n  = 1'b1;
      if (SETTLE_CYC == 0) begin
        state_n = (mode_n == MODE_AUTO) ? ST_DWELL : ST_MANUAL;
        cnt_n   = dwell_eff;
      end else begin
        state_n  = ST_SETTLE;
        settle_n = SETTLE_LD;
      end
    end
  end

  always_comb begin
    rd_n = rd_q;
    if (m_rd) begin
      if (m_addr == A_SEL)         rd_n = 16'(sel_q);
      else if (m_addr == A_MASK)   rd_n = 16'(mask_q);
      else if (m_addr == A_MODE)   rd_n = {15'd0, mode_q};
      else if (m_addr == A_DWELL)  rd_n = dwell_q;
      else if (m_addr == A_STATUS) rd_n = {8'h00, idx_q, 2'b00, ch_valid, err_q};
      else                         rd_n = '0;
    end
  end

  assign ch_valid  = (state_q != ST_SETTLE);
  assign ch_sel    = sel_q;
  assign ch_idx    = idx_q;
  assign ch_switch = sw_q;
  assign scan_wrap = wrap_q;
  assign m_rddata  = rd_q;

endmodule

// File: doc/ch_scan_ctrl.md
CH_SCAN_CTRL -- requirements
Module: ch_scan_ctrl

Interface
REQ-001 Parameter CH_NUM, default 4, number of signal channels (2..16).
REQ-002 Parameter DWELL_DEF, default 16'd1000, reset dwell length in Clk cycles.
REQ-003 Parameter SETTLE_CYC, default 8, blanking cycles after every channel change (0..255).
REQ-004 Parameter ADDR_BASE, default 8'h10, base address of the register window.
REQ-005 Clk  input  1  single system clock; all logic is on its rising edge.
REQ-006 Rst  input  1  asynchronous, active-high reset.
REQ-007 m_wr  input  1  host register-write request, one cycle per write.
REQ-008 m_rd  input  1  host register-read request, one cycle per read.
REQ-009 m_addr  input  8  host register address.
REQ-010 m_wrdata  input  16  host write data.
REQ-011 m_rddata  output  16  read data, valid the cycle after m_rd.
REQ-012 ch_sel  output  CH_NUM  one-hot active channel.
REQ-013 ch_idx  output  4  binary index of the active channel.
REQ-014 ch_valid  output  1  high when the active channel has settled.
REQ-015 ch_switch  output  1  one-cycle pulse on every channel change.
REQ-016 scan_wrap  output  1  one-cycle pulse when auto-scan wraps from the highest enabled channel to the lowest.

Function
REQ-017 Register map, offsets from ADDR_BASE: +0 CH_SEL (one-hot), +1 CH_MASK (scan enable bits), +2 MODE (bit0: 0 manual, 1 auto), +3 DWELL (16-bit), +4 STATUS (read-only: bit0 err_sticky, bit1 ch_valid, bits7:4 ch_idx); a write to STATUS clears err_sticky.
REQ-018 Write data bits above CH_NUM-1 for CH_SEL and CH_MASK are ignored; reads return them as 0.
REQ-019 A CH_SEL write whose low CH_NUM bits are not exactly one-hot is discarded and sets err_sticky.
REQ-020 FSM states: MANUAL, DWELL, SETTLE.
REQ-021 MANUAL: ch_sel changes only on a valid CH_SEL write; a change enters SETTLE.
REQ-022 A write of MODE=1 from MANUAL enters DWELL on the current channel with the dwell counter loaded from DWELL.
REQ-023 DWELL: the counter decrements every cycle; at count 1 the next enabled channel above ch_idx is selected and SETTLE is entered.
REQ-024 If no enabled channel lies above ch_idx, the lowest enabled channel is selected and scan_wrap pulses in the same cycle as ch_switch.
REQ-025 If CH_MASK is zero, or the only enabled channel is the current one, no change occurs, ch_switch does not pulse, and the counter reloads.
REQ-026 SETTLE: ch_valid is low for exactly SETTLE_CYC cycles after the change edge, then the FSM returns to DWELL (auto) or MANUAL.
REQ-027 With SETTLE_CYC = 0, ch_valid stays high through the change and ch_switch still pulses.
REQ-028 ch_switch and ch_sel update on the same clock edge.
REQ-029 DWELL = 0 is treated as 1.
REQ-030 A valid CH_SEL write in auto mode selects that channel immediately, enters SETTLE, and restarts the dwell count afterwards.
REQ-031 A MODE=0 write in any state stops scanning at the current channel; an in-progress SETTLE completes before the FSM enters MANUAL.
REQ-032 A DWELL write takes effect at the next counter load.
REQ-033 A CH_MASK write takes effect at the next channel decision.
REQ-034 If m_wr and a dwell expiry occur in the same cycle, the write is applied first; a CH_SEL write overrides the automatic step.

Reset
REQ-035 On Rst the outputs and registers SHALL take these values: ch_sel = 1 (channel 0), ch_idx = 0, ch_valid = 1, ch_switch = 0, scan_wrap = 0, m_rddata = 0, CH_MASK = all ones, MODE = 0, DWELL = DWELL_DEF, err_sticky = 0, FSM = MANUAL.
REQ-036 Reset asserted mid-SETTLE or mid-DWELL SHALL return the block to the reset state within the same cycle and leave no pending pulse.

Structure
REQ-037 Register offsets, MODE encoding and FSM state encoding SHALL live in the shared package ch_scan_pkg.
REQ-038 Next-enabled-channel search (wrap flag, index, one-hot result) SHALL be the single sub-module ch_next_sel.

Verification
REQ-039 Manual mode: write CH_SEL = 4'b0100 -> ch_sel = 0100, ch_idx = 2, ch_switch pulses once, ch_valid low for 8 cycles.
REQ-040 Invalid select: write CH_SEL = 4'b0110 -> ch_sel unchanged, STATUS bit0 = 1; write STATUS -> bit0 = 0.
REQ-041 Auto scan: CH_MASK = 1011, DWELL = 5, MODE = 1 -> sequence 0,1,3,0 with 5 + 8 cycles per step; scan_wrap pulses on the 3->0 step.
REQ-042 Degenerate mask: CH_MASK = 0000 in auto mode -> no ch_switch over 100 cycles.
REQ-043 Collision: CH_SEL = 0100 write in the cycle of dwell expiry -> channel 2 is selected, not the next scan channel.
REQ-044 Reset mid-operation: assert Rst during SETTLE -> ch_sel = 0001, ch_valid = 1, MODE = 0 immediately.
